// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
// Shared types and constants for the shared-comparator arbiter.
//   cmp_state_e : controller states (IDLE -> CMP -> RESP)
//   cmp_flags_t : one-hot magnitude result {lt, et, gt}
//   DEFAULT_WIDTH : default operand width
//   wrap_idx()  : modular index helper used by the round-robin search
// ---------------------------------------------------------------------------
package cmp_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic lt;
        logic et;
        logic gt;
    } cmp_flags_t;

    // Both base and off are below n, so one conditional subtract is enough
    // and no divider is needed for non-power-of-two requester counts.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/cmp_core.sv
// ---------------------------------------------------------------------------
// cmp_core
// Purely combinational unsigned magnitude comparator. This is the single
// comparator that all requesters of cmp_share_arb share.
// Ports:
//   a, b  : WIDTH-bit unsigned operands
//   flags : {lt, et, gt}, exactly one bit set
// ---------------------------------------------------------------------------
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_flags_t       flags
);

    logic is_lt;
    logic is_et;

    // gt is derived from the other two so the three flags are mutually
    // exclusive by construction and only one magnitude compare exists.
    always_comb begin
        is_lt    = (a < b);
        is_et    = (a == b);
        flags.lt = is_lt;
        flags.et = is_et;
        flags.gt = ~(is_lt | is_et);
    end

endmodule

// File: rtl/cmp_share_arb.sv
// ---------------------------------------------------------------------------
// cmp_share_arb
// Shares one WIDTH-bit unsigned comparator between NUM_REQ requesters.
// A round-robin search grants one requester in IDLE, its operands are
// latched, compared in CMP, and the registered result is held in RESP
// until the owning requester accepts it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester operand handshake (ready one-hot)
//   req_a, req_b        : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready : per-requester result handshake (valid one-hot)
//   rsp_lt/et/gt        : shared result flags, qualified by rsp_valid
//   busy                : high whenever the controller is not in IDLE
// ---------------------------------------------------------------------------
module cmp_share_arb
    import cmp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic                     rsp_lt,
    output logic                     rsp_et,
    output logic                     rsp_gt,
    output logic                     busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    cmp_state_e       state_q;
    cmp_state_e       state_d;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_q;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand;
    logic             gnt_found;
    logic             accept;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    cmp_flags_t       core_flags;
    cmp_flags_t       flags_q;

    // Round-robin search: first valid requester at or above rr_ptr, with
    // wrap. Priority rotates only through rr_ptr, never by fixed index.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'(wrap_idx(int'(rr_ptr), k, NUM_REQ));
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Accept is also gated by rst_n so req_ready drops the moment reset
    // asserts, even if requesters still hold req_valid.
    assign accept = rst_n && (state_q == IDLE) && gnt_found;

    // Controller next-state and handshake outputs. Requesters other than
    // the owner are ignored in CMP and RESP.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_d            = CMP;
                end
            end
            CMP: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[gnt_q] = 1'b1;
                if (rsp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping and operand capture. Operands are copied on the
    // accept edge so later changes on req_a/req_b cannot affect the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            gnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (accept) begin
            gnt_q  <= gnt_idx;
            a_q    <= req_a[gnt_idx*WIDTH +: WIDTH];
            b_q    <= req_b[gnt_idx*WIDTH +: WIDTH];
            rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
    end

    cmp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a_q),
        .b     (b_q),
        .flags (core_flags)
    );

    // Result flags are captured once at the end of CMP and stay frozen
    // through RESP, however long the owner applies backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (state_q == CMP) begin
            flags_q <= core_flags;
        end
    end

    assign rsp_lt = flags_q.lt;
    assign rsp_et = flags_q.et;
    assign rsp_gt = flags_q.gt;

endmodule

// File: tb/tb_cmp_share_arb.sv
// ---------------------------------------------------------------------------
// tb_cmp_share_arb
// Self-checking bench for cmp_share_arb (NUM_REQ=4, WIDTH=32). A reference
// model tracks the round-robin pointer as a plain integer and computes the
// expected result flags with arithmetic comparisons.
// ---------------------------------------------------------------------------
module tb_cmp_share_arb;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic           rsp_lt;
    logic           rsp_et;
    logic           rsp_gt;
    logic           busy;

    logic [W-1:0]   op_a [N];
    logic [W-1:0]   op_b [N];

    int n_checks;
    int n_fail;
    int model_ptr;

    cmp_share_arb #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_lt    (rsp_lt),
        .rsp_et    (rsp_et),
        .rsp_gt    (rsp_gt),
        .busy      (busy)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the per-requester operand arrays onto the DUT buses.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    end

    // Reference model: first valid requester at or after the pointer.
    function automatic int model_grant(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [2:0] model_flags(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a < b)  return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0 && g < N) v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic [2:0] obs_flags();
        return {rsp_lt, rsp_et, rsp_gt};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a grant; rdy is zero on timeout.
    task automatic wait_grant(output logic [N-1:0] rdy, output int cyc);
        cyc = 0;
        #1;
        rdy = req_ready;
        while (rdy == '0 && cyc < 16) begin
            tick();
            cyc++;
            rdy = req_ready;
        end
    endtask

    // Wait (bounded) for a response; rv is zero on timeout.
    task automatic wait_rsp(output logic [N-1:0] rv, output int cyc);
        cyc = 0;
        rv  = rsp_valid;
        while (rv == '0 && cyc < 16) begin
            tick();
            cyc++;
            rv = rsp_valid;
        end
    endtask

    task automatic test_reset();
        logic [N-1:0] rdy;
        logic [N-1:0] rv;
        int           cyc;
        int           g;
        $display("[TB] test_reset");
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, obs_flags(), busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b valid=%b flags=%b busy=%b, expected all 0",
                     req_ready, rsp_valid, obs_flags(), busy);
        end
        tick();
        rst_n     = 1'b1;
        model_ptr = 0;
        tick();
        // A completed transaction on requester 1 moves the pointer to 2.
        op_a[1]   = 32'd7;
        op_b[1]   = 32'd7;
        req_valid = 4'b0010;
        wait_grant(rdy, cyc);
        n_checks++;
        if (rdy !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_pre_grant: got %b expected 0010", rdy);
        end
        tick();
        model_ptr = 2;
        req_valid = '0;
        wait_rsp(rv, cyc);
        tick();
        // Start another transaction and reset while it is in CMP.
        op_a[2]   = 32'd1;
        op_b[2]   = 32'd2;
        req_valid = 4'b0100;
        wait_grant(rdy, cyc);
        tick();
        req_valid = '1;
        n_checks++;
        if (busy !== 1'b1 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_in_cmp: got busy=%b ready=%b expected busy=1 ready=0000", busy, req_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, obs_flags(), busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_cmp: got ready=%b valid=%b flags=%b busy=%b, expected all 0",
                     req_ready, rsp_valid, obs_flags(), busy);
        end
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        model_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (rsp_valid !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_stale_rsp: cycle %0d got valid=%b busy=%b expected 0000/0", i, rsp_valid, busy);
            end
        end
        // With every requester pending, a reset pointer grants requester 0.
        for (int i = 0; i < N; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
        end
        req_valid = '1;
        g = model_grant('1);
        wait_grant(rdy, cyc);
        n_checks++;
        if (rdy !== onehot(g)) begin
            n_fail++;
            $display("FAIL reset_ptr_zero: got %b expected %b", rdy, onehot(g));
        end
        tick();
        model_ptr = (g + 1) % N;
        req_valid = '0;
        wait_rsp(rv, cyc);
        tick();
    endtask

    task automatic test_single();
        logic [N-1:0] rdy;
        logic [N-1:0] rv;
        int           cyc;
        $display("[TB] test_single");
        rsp_ready = '1;
        op_a[2]   = 32'h0000_0005;
        op_b[2]   = 32'h0000_0009;
        req_valid = 4'b0100;
        wait_grant(rdy, cyc);
        n_checks++;
        if (rdy !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected 0100", rdy);
        end
        tick();
        model_ptr = 3;
        req_valid = '0;
        n_checks++;
        if (busy !== 1'b1 || rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL single_t1: got busy=%b valid=%b expected 1/0000", busy, rsp_valid);
        end
        wait_rsp(rv, cyc);
        n_checks++;
        if (rv !== 4'b0100 || cyc != 1) begin
            n_fail++;
            $display("FAIL single_latency: got valid=%b after %0d cycles expected 0100 after 1", rv, cyc);
        end
        n_checks++;
        if (obs_flags() !== 3'b100) begin
            n_fail++;
            $display("FAIL single_flags: got %b expected 100", obs_flags());
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== '0) begin
            n_fail++;
            $display("FAIL single_idle_t3: got busy=%b valid=%b expected 0/0000", busy, rsp_valid);
        end
    endtask

    task automatic test_unsigned();
        logic [W-1:0] pa [3];
        logic [W-1:0] pb [3];
        logic [2:0]   pf [3];
        logic [N-1:0] rdy;
        logic [N-1:0] rv;
        int           cyc;
        int           r;
        $display("[TB] test_unsigned");
        pa[0] = 32'hFFFF_FFFF; pb[0] = 32'h0000_0001; pf[0] = 3'b001;
        pa[1] = 32'h8000_0000; pb[1] = 32'h8000_0000; pf[1] = 3'b010;
        pa[2] = 32'h0000_0000; pb[2] = 32'hFFFF_FFFF; pf[2] = 3'b100;
        rsp_ready = '1;
        for (int i = 0; i < 3; i++) begin
            r         = $urandom_range(0, N - 1);
            op_a[r]   = pa[i];
            op_b[r]   = pb[i];
            req_valid = onehot(r);
            wait_grant(rdy, cyc);
            n_checks++;
            if (rdy !== onehot(model_grant(onehot(r)))) begin
                n_fail++;
                $display("FAIL unsigned_grant%0d: got %b expected %b", i, rdy, onehot(r));
            end
            tick();
            model_ptr = (r + 1) % N;
            req_valid = '0;
            wait_rsp(rv, cyc);
            n_checks++;
            if (rv !== onehot(r) || obs_flags() !== pf[i]) begin
                n_fail++;
                $display("FAIL unsigned_pair%0d: got valid=%b flags=%b expected valid=%b flags=%b",
                         i, rv, obs_flags(), onehot(r), pf[i]);
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] rdy;
        logic [N-1:0] rv;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        int           cyc;
        int           g;
        $display("[TB] test_round_robin");
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        model_ptr = 0;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
        end
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            g = model_grant('1);
            wait_grant(rdy, cyc);
            n_checks++;
            if (rdy !== onehot(k % N) || rdy !== onehot(g)) begin
                n_fail++;
                $display("FAIL rr_order%0d: got %b expected %b", k, rdy, onehot(k % N));
            end
            n_checks++;
            if ($countones(rdy) != 1) begin
                n_fail++;
                $display("FAIL rr_onehot%0d: got %b expected exactly one bit", k, rdy);
            end
            tick();
            model_ptr = (g + 1) % N;
            ea        = op_a[g];
            eb        = op_b[g];
            op_a[g]   = $urandom;
            op_b[g]   = $urandom;
            n_checks++;
            if (req_ready !== '0) begin
                n_fail++;
                $display("FAIL rr_ready_in_cmp%0d: got %b expected 0000", k, req_ready);
            end
            wait_rsp(rv, cyc);
            n_checks++;
            if (rv !== onehot(g) || obs_flags() !== model_flags(ea, eb)) begin
                n_fail++;
                $display("FAIL rr_result%0d: got valid=%b flags=%b expected valid=%b flags=%b",
                         k, rv, obs_flags(), onehot(g), model_flags(ea, eb));
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] rdy;
        logic [N-1:0] rv;
        logic [2:0]   ef;
        int           cyc;
        int           g;
        $display("[TB] test_backpressure");
        rsp_ready    = '1;
        rsp_ready[1] = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = $urandom;
            op_b[i] = $urandom;
        end
        ef        = model_flags(op_a[1], op_b[1]);
        req_valid = 4'b0010;
        wait_grant(rdy, cyc);
        n_checks++;
        if (rdy !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_grant: got %b expected 0010", rdy);
        end
        tick();
        model_ptr = 2;
        req_valid = 4'b1101;
        wait_rsp(rv, cyc);
        n_checks++;
        if (rv !== 4'b0010 || obs_flags() !== ef) begin
            n_fail++;
            $display("FAIL bp_first_rsp: got valid=%b flags=%b expected 0010/%b", rv, obs_flags(), ef);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 4'b0010 || obs_flags() !== ef || req_ready !== '0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b flags=%b ready=%b busy=%b expected 0010/%b/0000/1",
                         i, rsp_valid, obs_flags(), req_ready, busy, ef);
            end
        end
        rsp_ready[1] = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0010 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b ready=%b expected 0010/0000", rsp_valid, req_ready);
        end
        tick();
        g = model_grant(4'b1101);
        n_checks++;
        if (req_ready !== onehot(g)) begin
            n_fail++;
            $display("FAIL bp_next_grant: got %b expected %b", req_ready, onehot(g));
        end
        ef = model_flags(op_a[g], op_b[g]);
        tick();
        model_ptr = (g + 1) % N;
        req_valid = '0;
        wait_rsp(rv, cyc);
        n_checks++;
        if (rv !== onehot(g) || obs_flags() !== ef) begin
            n_fail++;
            $display("FAIL bp_next_result: got valid=%b flags=%b expected %b/%b", rv, obs_flags(), onehot(g), ef);
        end
        tick();
    endtask

    task automatic test_operand_stability();
        logic [N-1:0] rdy;
        logic [N-1:0] rv;
        int           cyc;
        $display("[TB] test_operand_stability");
        rsp_ready = '1;
        op_a[0]   = 32'd3;
        op_b[0]   = 32'd50;
        req_valid = 4'b0001;
        wait_grant(rdy, cyc);
        n_checks++;
        if (rdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL stab_grant: got %b expected 0001", rdy);
        end
        tick();
        model_ptr = 1;
        req_valid = '0;
        op_a[0]   = 32'd100;
        wait_rsp(rv, cyc);
        n_checks++;
        if (rv !== 4'b0001 || obs_flags() !== 3'b100) begin
            n_fail++;
            $display("FAIL stab_result: got valid=%b flags=%b expected 0001/100", rv, obs_flags());
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] rdy;
        logic [N-1:0] rv;
        logic [N-1:0] mask;
        logic [2:0]   ef;
        int           cyc;
        int           g;
        int           delay;
        $display("[TB] test_random");
        for (int t = 0; t < 40; t++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                op_a[i] = $urandom;
                op_b[i] = ($urandom_range(0, 3) == 0) ? op_a[i] : $urandom;
            end
            delay     = $urandom_range(0, 3);
            rsp_ready = '1;
            req_valid = mask;
            g         = model_grant(mask);
            ef        = model_flags(op_a[g], op_b[g]);
            wait_grant(rdy, cyc);
            n_checks++;
            if (rdy !== onehot(g) || cyc != 0) begin
                n_fail++;
                $display("FAIL rand_grant%0d: got %b after %0d cycles expected %b after 0", t, rdy, cyc, onehot(g));
            end
            tick();
            model_ptr    = (g + 1) % N;
            req_valid[g] = 1'b0;
            op_a[g]      = $urandom;
            op_b[g]      = $urandom;
            rsp_ready    = N'($urandom);
            rsp_ready[g] = (delay == 0);
            wait_rsp(rv, cyc);
            n_checks++;
            if (rv !== onehot(g) || cyc != 1 || obs_flags() !== ef) begin
                n_fail++;
                $display("FAIL rand_result%0d: got valid=%b lat=%0d flags=%b expected %b/1/%b",
                         t, rv, cyc, obs_flags(), onehot(g), ef);
            end
            for (int d = 0; d < delay; d++) begin
                tick();
                n_checks++;
                if (rsp_valid !== onehot(g) || obs_flags() !== ef || req_ready !== '0) begin
                    n_fail++;
                    $display("FAIL rand_hold%0d_%0d: got valid=%b flags=%b ready=%b expected %b/%b/0000",
                             t, d, rsp_valid, obs_flags(), req_ready, onehot(g), ef);
                end
            end
            rsp_ready[g] = 1'b1;
            tick();
        end
        req_valid = '0;
        rsp_ready = '1;
        tick();
    endtask

    // Absolute time bound so a stuck DUT still ends the run.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_ptr = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        test_reset();
        test_single();
        test_unsigned();
        test_round_robin();
        test_backpressure();
        test_operand_stability();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
